// File: rtl/ascon_aead_ctrl.sv
// ASCON-128 AEAD sequencing controller: steps the datapath through init, AD, text, final and tag,
// handshaking with an external permutation core and checking the tag on decrypt.
module ascon_aead_ctrl #(
  parameter int MAX_AD_BLOCKS  = 15,
  parameter int MAX_TXT_BLOCKS = 15,
  parameter int ROUNDS_A       = 12,
  parameter int ROUNDS_B       = 6,
  parameter int TAG_W          = 128,
  localparam int AD_W  = $clog2(MAX_AD_BLOCKS + 1),
  localparam int TXT_W = $clog2(MAX_TXT_BLOCKS + 1),
  localparam int IDX_W = (AD_W > TXT_W) ? AD_W : TXT_W
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [AD_W-1:0]  ad_blocks_i,
  input  logic [TXT_W-1:0] txt_blocks_i,
  input  logic             data_valid_i,
  output logic             data_ready_o,
  output logic             perm_start_o,
  output logic [3:0]       perm_rounds_o,
  input  logic             perm_done_i,
  output logic             load_init_o,
  output logic             xor_key_init_o,
  output logic             xor_data_o,
  output logic             data_replace_o,
  output logic             xor_domain_o,
  output logic             xor_key_final_o,
  output logic             cipher_valid_o,
  input  logic [TAG_W-1:0] tag_i,
  input  logic [TAG_W-1:0] tag_ref_i,
  output logic             tag_valid_o,
  output logic             tag_ok_o,
  output logic [IDX_W-1:0] block_idx_o,
  output logic             busy_o,
  output logic             end_o
);

  // state      | meaning
  // IDLE       | waiting for start
  // LOAD       | load IV||K||N
  // INIT_PERM  | ROUNDS_A permutation
  // INIT_KEY   | XOR 0*||K
  // AD_WAIT    | wait for an AD block
  // AD_PERM    | ROUNDS_B permutation after an AD block
  // DOMAIN     | XOR domain-separation bit
  // TXT_WAIT   | wait for a text block
  // TXT_PERM   | ROUNDS_B permutation after a non-last text block
  // FINAL_KEY  | XOR K into S1,S2
  // FINAL_PERM | ROUNDS_A permutation
  // TAG        | release and check tag
  typedef enum logic [3:0] {
    IDLE, LOAD, INIT_PERM, INIT_KEY, AD_WAIT, AD_PERM, DOMAIN,
    TXT_WAIT, TXT_PERM, FINAL_KEY, FINAL_PERM, TAG
  } state_t;

  localparam logic [AD_W-1:0]  AD_MAX  = AD_W'(MAX_AD_BLOCKS);
  localparam logic [TXT_W-1:0] TXT_MAX = TXT_W'(MAX_TXT_BLOCKS);
  localparam logic [3:0]       RND_A   = 4'(ROUNDS_A);
  localparam logic [3:0]       RND_B   = 4'(ROUNDS_B);

  state_t           state, next_state;
  logic             mode;
  logic [IDX_W-1:0] ad_cnt, txt_cnt, idx, idx_next;
  logic [AD_W-1:0]  ad_sat;
  logic [TXT_W-1:0] txt_sat;
  logic             next_is_perm;

  always_comb begin
    ad_sat = (ad_blocks_i > AD_MAX) ? AD_MAX : ad_blocks_i;
    if (txt_blocks_i == '0)
      txt_sat = TXT_W'(1);
    else if (txt_blocks_i > TXT_MAX)
      txt_sat = TXT_MAX;
    else
      txt_sat = txt_blocks_i;
  end

  always_comb begin
    next_state     = state;
    idx_next       = idx;
    data_ready_o   = 1'b0;
    xor_data_o     = 1'b0;
    data_replace_o = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          next_state = LOAD;
          idx_next   = '0;
        end
      end
      LOAD:      next_state = INIT_PERM;
      INIT_PERM: if (perm_done_i) next_state = INIT_KEY;
      INIT_KEY:  next_state = (ad_cnt != '0) ? AD_WAIT : DOMAIN;
      AD_WAIT: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          xor_data_o = 1'b1;
          next_state = AD_PERM;
        end
      end
      AD_PERM: begin
        if (perm_done_i) begin
          if (idx == ad_cnt - IDX_W'(1)) begin
            idx_next   = '0;
            next_state = DOMAIN;
          end else begin
            idx_next   = idx + IDX_W'(1);
            next_state = AD_WAIT;
          end
        end
      end
      DOMAIN: next_state = TXT_WAIT;
      TXT_WAIT: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          xor_data_o     = 1'b1;
          data_replace_o = mode;
          // the last text block goes straight to finalisation without a permutation
          next_state     = (idx < txt_cnt - IDX_W'(1)) ? TXT_PERM : FINAL_KEY;
        end
      end
      TXT_PERM: begin
        if (perm_done_i) begin
          idx_next   = idx + IDX_W'(1);
          next_state = TXT_WAIT;
        end
      end
      FINAL_KEY:  next_state = FINAL_PERM;
      FINAL_PERM: if (perm_done_i) next_state = TAG;
      TAG:        next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  assign next_is_perm = (next_state == INIT_PERM) || (next_state == AD_PERM) ||
                        (next_state == TXT_PERM) || (next_state == FINAL_PERM);

  // outputs are registered from next_state so they line up with the state they describe
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state           <= IDLE;
      idx             <= '0;
      mode            <= 1'b0;
      ad_cnt          <= '0;
      txt_cnt         <= '0;
      perm_start_o    <= 1'b0;
      perm_rounds_o   <= '0;
      load_init_o     <= 1'b0;
      xor_key_init_o  <= 1'b0;
      xor_domain_o    <= 1'b0;
      xor_key_final_o <= 1'b0;
      cipher_valid_o  <= 1'b0;
      tag_valid_o     <= 1'b0;
      tag_ok_o        <= 1'b0;
      busy_o          <= 1'b0;
      end_o           <= 1'b0;
    end else begin
      state <= next_state;
      idx   <= idx_next;
      if (state == IDLE && start_i) begin
        mode     <= mode_i;
        ad_cnt   <= IDX_W'(ad_sat);
        txt_cnt  <= IDX_W'(txt_sat);
        end_o    <= 1'b0;
        tag_ok_o <= 1'b0;
      end
      if (state == TAG) begin
        end_o    <= 1'b1;
        tag_ok_o <= !mode || (tag_i == tag_ref_i);
      end
      perm_start_o <= next_is_perm && (next_state != state);
      case (next_state)
        INIT_PERM, FINAL_PERM: perm_rounds_o <= RND_A;
        AD_PERM, TXT_PERM:     perm_rounds_o <= RND_B;
        default:               perm_rounds_o <= '0;
      endcase
      load_init_o     <= (next_state == LOAD);
      xor_key_init_o  <= (next_state == INIT_KEY);
      xor_domain_o    <= (next_state == DOMAIN);
      xor_key_final_o <= (next_state == FINAL_KEY);
      cipher_valid_o  <= (state == TXT_WAIT) && data_valid_i;
      tag_valid_o     <= (next_state == TAG);
      busy_o          <= (next_state != IDLE);
    end
  end

  assign block_idx_o = idx;

endmodule

// File: tb/tb_ascon_aead_ctrl.sv
// Directed bench for ascon_aead_ctrl: a behavioural permutation core plus event counters,
// with hand-computed expectations per message.
module tb_ascon_aead_ctrl;
  localparam int MAX_AD = 12;

  logic         clock_i = 1'b0;
  logic         reset_i, start_i, mode_i, data_valid_i, perm_done_i;
  logic [3:0]   ad_blocks_i, txt_blocks_i;
  logic [127:0] tag_i, tag_ref_i;
  logic         data_ready_o, perm_start_o, load_init_o, xor_key_init_o, xor_data_o;
  logic         data_replace_o, xor_domain_o, xor_key_final_o, cipher_valid_o;
  logic         tag_valid_o, tag_ok_o, busy_o, end_o;
  logic [3:0]   perm_rounds_o, block_idx_o;

  ascon_aead_ctrl #(.MAX_AD_BLOCKS(MAX_AD)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .mode_i(mode_i),
    .ad_blocks_i(ad_blocks_i), .txt_blocks_i(txt_blocks_i),
    .data_valid_i(data_valid_i), .data_ready_o(data_ready_o),
    .perm_start_o(perm_start_o), .perm_rounds_o(perm_rounds_o), .perm_done_i(perm_done_i),
    .load_init_o(load_init_o), .xor_key_init_o(xor_key_init_o), .xor_data_o(xor_data_o),
    .data_replace_o(data_replace_o), .xor_domain_o(xor_domain_o),
    .xor_key_final_o(xor_key_final_o), .cipher_valid_o(cipher_valid_o),
    .tag_i(tag_i), .tag_ref_i(tag_ref_i), .tag_valid_o(tag_valid_o), .tag_ok_o(tag_ok_o),
    .block_idx_o(block_idx_o), .busy_o(busy_o), .end_o(end_o)
  );

  always #5 clock_i = ~clock_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int         perm_cnt = 0;
  logic [3:0] rounds_log [32];
  int         n_perm, n_cipher, n_tagv, n_xor, n_repl, n_load, max_idx;
  logic       prev_key, dom_after_key;

  // permutation core model (done N cycles after start) and event counters, all on the falling edge
  always @(negedge clock_i) begin
    if (reset_i) begin
      perm_cnt    = 0;
      perm_done_i = 1'b0;
    end else if (perm_start_o) begin
      perm_cnt    = int'(perm_rounds_o);
      perm_done_i = 1'b0;
      if (n_perm < 32) rounds_log[n_perm] = perm_rounds_o;
      n_perm++;
    end else if (perm_cnt != 0) begin
      perm_cnt--;
      perm_done_i = (perm_cnt == 0);
    end else begin
      perm_done_i = 1'b0;
    end
    if (cipher_valid_o) n_cipher++;
    if (tag_valid_o)    n_tagv++;
    if (xor_data_o)     n_xor++;
    if (data_replace_o) n_repl++;
    if (load_init_o)    n_load++;
    if (xor_domain_o && prev_key) dom_after_key = 1'b1;
    prev_key = xor_key_init_o;
    if (busy_o && int'(block_idx_o) > max_idx) max_idx = int'(block_idx_o);
  end

  function automatic logic [20:0] all_outs();
    return {data_ready_o, perm_start_o, perm_rounds_o, load_init_o, xor_key_init_o,
            xor_data_o, data_replace_o, xor_domain_o, xor_key_final_o, cipher_valid_o,
            tag_valid_o, tag_ok_o, block_idx_o, busy_o, end_o};
  endfunction

  task automatic start_msg(input logic m, input logic [3:0] ad, input logic [3:0] txt,
                           input logic [127:0] ref_tag);
    @(negedge clock_i);
    mode_i = m; ad_blocks_i = ad; txt_blocks_i = txt; tag_ref_i = ref_tag;
    n_perm = 0; n_cipher = 0; n_tagv = 0; n_xor = 0; n_repl = 0; n_load = 0;
    max_idx = 0; dom_after_key = 1'b0;
    start_i = 1'b1;
    @(negedge clock_i);
    start_i = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int k = 0;
    while (!end_o && k < 2000) begin
      @(negedge clock_i);
      k++;
    end
    check({tag, "_end"}, end_o, 1'b1);
  endtask

  logic [127:0] tag_val;
  int           k;

  initial begin
    tag_val = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_32a5;
    tag_i = tag_val; tag_ref_i = '0;
    reset_i = 1'b1; start_i = 1'b0; mode_i = 1'b0; ad_blocks_i = '0; txt_blocks_i = '0;
    data_valid_i = 1'b1; perm_done_i = 1'b0; prev_key = 1'b0; dom_after_key = 1'b0;
    n_perm = 0; n_cipher = 0; n_tagv = 0; n_xor = 0; n_repl = 0; n_load = 0; max_idx = 0;
    repeat (3) @(negedge clock_i);
    check("reset_outs", 64'(all_outs()), 64'd0);
    reset_i = 1'b0;
    @(negedge clock_i);
    check("idle_outs", 64'(all_outs()), 64'd0);

    // encrypt, ad=1, txt=3
    start_msg(1'b0, 4'd1, 4'd3, tag_val);
    check("enc_busy", busy_o, 1'b1);
    wait_end("enc");
    check("enc_nperm", n_perm, 5);
    check("enc_rounds", {rounds_log[0], rounds_log[1], rounds_log[2], rounds_log[3], rounds_log[4]},
          {4'd12, 4'd6, 4'd6, 4'd6, 4'd12});
    check("enc_cipher", n_cipher, 3);
    check("enc_tagv", n_tagv, 1);
    check("enc_xor", n_xor, 4);
    check("enc_repl", n_repl, 0);
    check("enc_tag_ok", tag_ok_o, 1'b1);
    check("enc_maxidx", max_idx, 2);
    check("enc_dom_direct", dom_after_key, 1'b0);
    @(negedge clock_i);
    check("enc_idle_busy", busy_o, 1'b0);
    check("enc_end_sticky", end_o, 1'b1);

    // decrypt, ad=0, txt=1, matching tag
    start_msg(1'b1, 4'd0, 4'd1, tag_val);
    check("dec_end_cleared", end_o, 1'b0);
    wait_end("dec");
    check("dec_dom_direct", dom_after_key, 1'b1);
    check("dec_nperm", n_perm, 2);
    check("dec_rounds", {rounds_log[0], rounds_log[1]}, {4'd12, 4'd12});
    check("dec_repl", n_repl, 1);
    check("dec_cipher", n_cipher, 1);
    check("dec_tag_ok", tag_ok_o, 1'b1);

    // decrypt, ad=2, txt=2, tag mismatch
    start_msg(1'b1, 4'd2, 4'd2, tag_val ^ 128'd1);
    wait_end("bad");
    check("bad_tag_ok", tag_ok_o, 1'b0);
    check("bad_nperm", n_perm, 5);
    check("bad_repl", n_repl, 2);

    // start pulsed during AD_PERM with data_valid held high
    start_msg(1'b0, 4'd2, 4'd1, tag_val);
    k = 0;
    while (n_xor < 1 && k < 500) begin
      @(negedge clock_i);
      k++;
    end
    check("ign_first_xor", n_xor, 1);
    repeat (2) @(negedge clock_i);
    check("ign_in_ad_perm", perm_rounds_o, 4'd6);
    start_i = 1'b1;
    @(negedge clock_i);
    start_i = 1'b0;
    check("ign_busy", busy_o, 1'b1);
    check("ign_ready", data_ready_o, 1'b0);
    wait_end("ign");
    check("ign_load", n_load, 1);
    check("ign_xor", n_xor, 3);
    check("ign_nperm", n_perm, 4);

    // reset mid TXT_PERM, then a clean message
    start_msg(1'b0, 4'd0, 4'd3, tag_val);
    k = 0;
    while (n_cipher < 1 && k < 500) begin
      @(negedge clock_i);
      k++;
    end
    check("rst_reach_txt", n_cipher, 1);
    repeat (2) @(negedge clock_i);
    check("rst_in_txt_perm", perm_rounds_o, 4'd6);
    reset_i = 1'b1;
    @(negedge clock_i);
    reset_i = 1'b0;
    check("rst_outs", 64'(all_outs()), 64'd0);
    start_msg(1'b0, 4'd1, 4'd2, tag_val);
    wait_end("rerun");
    check("rerun_rounds", {rounds_log[0], rounds_log[1], rounds_log[2], rounds_log[3]},
          {4'd12, 4'd6, 4'd6, 4'd12});
    check("rerun_nperm", n_perm, 4);
    check("rerun_cipher", n_cipher, 2);
    check("rerun_tag_ok", tag_ok_o, 1'b1);

    // txt=0 treated as 1, ad=15 saturates to MAX_AD=12
    start_msg(1'b0, 4'd15, 4'd0, tag_val);
    wait_end("sat");
    check("sat_xor", n_xor, 13);
    check("sat_cipher", n_cipher, 1);
    check("sat_nperm", n_perm, 14);
    check("sat_maxidx", max_idx, 11);
    check("sat_last_round", rounds_log[13], 4'd12);
    check("sat_ad_round", rounds_log[12], 4'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
